// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates coin credit, dispenses one product per valid
// selection and pays back the remainder as a paced train of fixed-value change pulses.
module vend_credit_ctrl #(
  parameter int NUM_SEL     = 4,
  parameter int CREDIT_W    = 8,
  parameter int PRICE       = 20,
  parameter int MAX_CREDIT  = 95,
  parameter int CHANGE_UNIT = 5,
  parameter int CHANGE_GAP  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic [NUM_SEL-1:0]  sel,
  input  logic                cancel,
  input  logic [NUM_SEL-1:0]  stock_empty,
  output logic [CREDIT_W-1:0] credit,
  output logic [NUM_SEL-1:0]  vend,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  localparam int CW1   = CREDIT_W + 1;
  localparam int GAP_W = (CHANGE_GAP > 0) ? $clog2(CHANGE_GAP + 1) : 1;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [CREDIT_W:0]   MAX_C   = CW1'(MAX_CREDIT);
  localparam logic [GAP_W-1:0]    GAP_C   = GAP_W'(CHANGE_GAP);

  state_t              state_q, state_n;
  logic [CREDIT_W-1:0] credit_q, credit_n;
  logic [NUM_SEL-1:0]  vend_q, vend_n;
  logic                pulse_q, pulse_n;
  logic                reject_q, reject_n;
  logic                busy_q;
  logic [GAP_W-1:0]    gap_q, gap_n;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                coin_taken;
  logic                sel_ok;
  logic [CREDIT_W-1:0] remainder;
  logic [CREDIT_W-1:0] after_pulse;
  logic                dec_en;
  logic [CREDIT_W-1:0] dec_val;

  always_comb begin
    unique case (coin_code)
      2'b01:   coin_val = CREDIT_W'(5);
      2'b10:   coin_val = CREDIT_W'(10);
      2'b11:   coin_val = CREDIT_W'(25);
      default: coin_val = '0;
    endcase
  end

  // The extra sum bit keeps a wrap-around from looking like a small, acceptable credit.
  assign coin_sum    = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits   = (coin_sum <= MAX_C);
  assign sel_ok      = $onehot(sel) && (credit_q >= PRICE_C) && ((sel & stock_empty) == '0);
  assign remainder   = credit_q - PRICE_C;
  assign after_pulse = credit_q - UNIT_C;

  // NOTE: every signal assigned here gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    state_n    = state_q;
    credit_n   = credit_q;
    vend_n     = '0;
    pulse_n    = 1'b0;
    gap_n      = gap_q;
    coin_taken = 1'b0;
    dec_en     = 1'b0;
    dec_val    = credit_q;

    unique case (state_q)
      S_IDLE: begin
        if (coin_valid && (coin_val != '0) && coin_fits) begin
          credit_n   = coin_sum[CREDIT_W-1:0];
          state_n    = S_CREDIT;
          coin_taken = 1'b1;
        end
      end

      S_CREDIT: begin
        if (cancel) begin
          state_n = S_CHANGE;
          gap_n   = '0;
          pulse_n = (credit_q >= UNIT_C);
        end else if (sel_ok) begin
          state_n = S_VEND;
          vend_n  = sel;
        end else if (coin_valid && (coin_val != '0) && coin_fits) begin
          credit_n   = coin_sum[CREDIT_W-1:0];
          coin_taken = 1'b1;
        end
      end

      S_VEND: begin
        credit_n = remainder;
        if (remainder == '0) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_CHANGE;
          gap_n   = '0;
          pulse_n = (remainder >= UNIT_C);
        end
      end

      S_CHANGE: begin
        if (pulse_q) begin
          // The unit paid out by the pulse now ending leaves the credit here.
          credit_n = after_pulse;
          if (after_pulse == '0) begin
            state_n = S_IDLE;
            gap_n   = '0;
          end else if (CHANGE_GAP == 0) begin
            dec_en  = 1'b1;
            dec_val = after_pulse;
          end else begin
            gap_n = GAP_C;
          end
        end else if (gap_q > GAP_W'(1)) begin
          gap_n = gap_q - GAP_W'(1);
        end else begin
          gap_n  = '0;
          dec_en = 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase

    // Next-pulse decision: pay another unit, or drop a sub-unit residue and finish.
    if (dec_en) begin
      if (dec_val >= UNIT_C) begin
        pulse_n = 1'b1;
      end else begin
        credit_n = '0;
        state_n  = S_IDLE;
      end
    end

    reject_n = coin_valid && (coin_val != '0) && !coin_taken;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      vend_q   <= '0;
      pulse_q  <= 1'b0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_n;
      credit_q <= credit_n;
      vend_q   <= vend_n;
      pulse_q  <= pulse_n;
      reject_q <= reject_n;
      busy_q   <= (state_n == S_VEND) || (state_n == S_CHANGE);
      gap_q    <= gap_n;
    end
  end

  assign credit       = credit_q;
  assign vend         = vend_q;
  assign change_pulse = pulse_q;
  assign coin_reject  = reject_q;
  assign busy         = busy_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: directed vector table, hand-written corner sequences and
// a randomized run against a change-schedule reference model.
module tb_vend_credit_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_code = 2'b00;
  logic [3:0] sel = 4'b0;
  logic       cancel = 1'b0;
  logic [3:0] stock_empty = 4'b0;
  logic [7:0] credit;
  logic [3:0] vend;
  logic       change_pulse;
  logic       coin_reject;
  logic       busy;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  vend_credit_ctrl #(
    .NUM_SEL(4), .CREDIT_W(8), .PRICE(20), .MAX_CREDIT(95), .CHANGE_UNIT(5), .CHANGE_GAP(1)
  ) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_code(coin_code), .sel(sel),
    .cancel(cancel), .stock_empty(stock_empty), .credit(credit), .vend(vend),
    .change_pulse(change_pulse), .coin_reject(coin_reject), .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_cr, input int e_vend, input int e_p,
                           input int e_rej, input int e_st);
    check({tag, " credit"}, 32'(credit), 32'(e_cr));
    check({tag, " vend"}, 32'(vend), 32'(e_vend));
    check({tag, " change_pulse"}, 32'(change_pulse), 32'(e_p));
    check({tag, " coin_reject"}, 32'(coin_reject), 32'(e_rej));
    check({tag, " state"}, 32'(state_o), 32'(e_st));
    check({tag, " busy"}, 32'(busy), 32'(e_st >= 2));
  endtask

  // Inputs change 1ns after a rising edge and hold until the next one.
  task automatic drive(input bit r, input bit cv, input logic [1:0] code, input logic [3:0] s,
                       input bit c, input logic [3:0] e);
    reset = r; coin_valid = cv; coin_code = code; sel = s; cancel = c; stock_empty = e;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r; bit cv; logic [1:0] code; logic [3:0] s; bit c; logic [3:0] e;
    int cr; int vd; int p; int rej; int st;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit r, bit cv, logic [1:0] code, logic [3:0] s, bit c,
                              logic [3:0] e, int cr, int vd, int p, int rej, int st);
    vec_t v;
    v.r = r; v.cv = cv; v.code = code; v.s = s; v.c = c; v.e = e;
    v.cr = cr; v.vd = vd; v.p = p; v.rej = rej; v.st = st;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  typedef struct { int st; int cr; int p; } sched_t;
  sched_t sq[$];
  int m_st, m_cr;

  // Lays out the whole payout as a per-cycle schedule, ending with the return to idle.
  function automatic void build_payout(int v);
    sched_t x;
    sq.delete();
    if (v < 5) begin
      x.st = 3; x.cr = v; x.p = 0; sq.push_back(x);
    end
    while (v >= 5) begin
      x.st = 3; x.cr = v; x.p = 1; sq.push_back(x);
      v -= 5;
      if (v > 0) begin
        x.st = 3; x.cr = v; x.p = 0; sq.push_back(x);
      end
    end
    x.st = 0; x.cr = 0; x.p = 0; sq.push_back(x);
  endfunction

  function automatic int pop_payout();
    sched_t x;
    x = sq.pop_front();
    m_st = x.st;
    m_cr = x.cr;
    return x.p;
  endfunction

  function automatic void model_step(bit cv, logic [1:0] code, logic [3:0] s, bit c,
                                     logic [3:0] e, output int ev, output int ep,
                                     output int er);
    int  val;
    bit  taken;
    val   = (code == 2'd1) ? 5 : (code == 2'd2) ? 10 : (code == 2'd3) ? 25 : 0;
    taken = 0; ev = 0; ep = 0;
    if (m_st == 2) begin
      if (m_cr - 20 == 0) begin m_st = 0; m_cr = 0; end
      else begin build_payout(m_cr - 20); ep = pop_payout(); end
    end else if (m_st == 3) begin
      ep = pop_payout();
    end else if (m_st == 1 && c) begin
      build_payout(m_cr);
      ep = pop_payout();
    end else if (m_st == 1 && $countones(s) == 1 && m_cr >= 20 && (s & e) == 4'b0) begin
      m_st = 2;
      ev = int'(s);
    end else if (cv && val > 0 && m_cr + val <= 95) begin
      m_cr += val;
      m_st = 1;
      taken = 1;
    end
    er = (cv && val > 0 && !taken) ? 1 : 0;
  endfunction

  initial begin
    int ev, ep, er, pulses, budget;
    logic [1:0] rc;
    logic [3:0] rs, re;
    bit rcv, rcan;

    // Tests 1..5 and idle/cancel-priority corners as a cycle-by-cycle table.
    add(1,0,0,0,0,0,   0,0,0,0,0);
    add(0,1,2,0,0,0,  10,0,0,0,1);
    add(0,1,2,0,0,0,  20,0,0,0,1);
    add(0,0,0,1,0,0,  20,1,0,0,2);
    add(0,0,0,0,0,0,   0,0,0,0,0);
    add(0,1,3,0,0,0,  25,0,0,0,1);
    add(0,0,0,4,0,0,  25,4,0,0,2);
    add(0,0,0,0,0,0,   5,0,1,0,3);
    add(0,0,0,0,0,0,   0,0,0,0,0);
    add(0,1,3,0,0,0,  25,0,0,0,1);
    add(0,1,3,0,0,0,  50,0,0,0,1);
    add(0,1,3,0,0,0,  75,0,0,0,1);
    add(0,1,2,0,0,0,  85,0,0,0,1);
    add(0,1,1,0,0,0,  90,0,0,0,1);
    add(0,1,3,0,0,0,  90,0,0,1,1);
    add(1,0,0,0,0,0,   0,0,0,0,0);
    add(0,1,2,0,0,0,  10,0,0,0,1);
    add(0,0,0,0,1,0,  10,0,1,0,3);
    add(0,0,0,0,0,0,   5,0,0,0,3);
    add(0,0,0,0,0,0,   5,0,1,0,3);
    add(0,0,0,0,0,0,   0,0,0,0,0);
    add(0,1,2,0,0,0,  10,0,0,0,1);
    add(0,1,1,0,0,0,  15,0,0,0,1);
    add(0,0,0,1,0,0,  15,0,0,0,1);
    add(0,1,1,0,0,0,  20,0,0,0,1);
    add(0,0,0,3,0,0,  20,0,0,0,1);
    add(0,0,0,1,0,1,  20,0,0,0,1);
    add(0,1,2,2,0,0,  20,2,0,1,2);
    add(0,1,1,0,0,0,   0,0,0,1,0);
    add(0,1,3,0,0,0,  25,0,0,0,1);
    add(0,0,0,0,1,0,  25,0,1,0,3);
    add(0,1,2,0,0,0,  20,0,0,1,3);
    add(0,0,0,0,0,0,  20,0,1,0,3);
    add(0,0,0,1,1,0,  15,0,0,0,3);
    add(1,0,0,0,0,0,   0,0,0,0,0);
    add(0,1,0,0,0,0,   0,0,0,0,0);
    add(0,0,0,1,1,0,   0,0,0,0,0);
    add(0,1,3,1,1,0,  25,0,0,0,1);
    add(0,1,2,0,1,0,  25,0,1,1,3);
    add(1,0,0,0,0,0,   0,0,0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].cv, vecs[i].code, vecs[i].s, vecs[i].c, vecs[i].e);
      check_all($sformatf("vec%0d", i), vecs[i].cr, vecs[i].vd, vecs[i].p, vecs[i].rej,
                vecs[i].st);
      reset = 1'b0;
    end

    // Reset asserted in the middle of a change cycle with 15 cents outstanding.
    drive(0,1,2,0,0,0);
    drive(0,1,1,0,0,0);
    drive(0,0,0,0,1,0);
    check("midreset pre pulse", 32'(change_pulse), 32'd1);
    check("midreset pre credit", 32'(credit), 32'd15);
    #2 reset = 1'b1;
    #1 check_all("midreset", 0, 0, 0, 0, 0);
    drive(1,0,0,0,0,0);
    drive(0,0,0,0,0,0);
    check_all("postreset", 0, 0, 0, 0, 0);

    // Exactly MAX_CREDIT is accepted, then a vend pays out 75 cents as 15 pulses.
    drive(0,1,3,0,0,0);
    drive(0,1,3,0,0,0);
    drive(0,1,3,0,0,0);
    drive(0,1,2,0,0,0);
    drive(0,1,2,0,0,0);
    check("max credit", 32'(credit), 32'd95);
    drive(0,1,1,0,0,0);
    check("over max reject", 32'(coin_reject), 32'd1);
    check("over max credit", 32'(credit), 32'd95);
    drive(0,0,0,8,0,0);
    check("max vend", 32'(vend), 32'd8);
    pulses = 0;
    budget = 100;
    drive(0,0,0,0,0,0);
    while (state_o != 2'd0 && budget > 0) begin
      pulses += int'(change_pulse);
      drive(0,0,0,0,0,0);
      budget--;
    end
    check("payout finished in budget", 32'(budget > 0), 32'd1);
    check("payout pulse count", 32'(pulses), 32'd15);
    check("payout final credit", 32'(credit), 32'd0);

    // Randomized run against the reference model.
    drive(1,0,0,0,0,0);
    m_st = 0; m_cr = 0; sq.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rcv  = ($urandom_range(0, 9) < 4);
      rc   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        6, 7, 9: rs = 4'(1 << $urandom_range(0, 3));
        8:       rs = 4'($urandom_range(0, 15));
        default: rs = 4'b0;
      endcase
      rcan = ($urandom_range(0, 29) == 0);
      re   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      model_step(rcv, rc, rs, rcan, re, ev, ep, er);
      drive(0, rcv, rc, rs, rcan, re);
      check_all($sformatf("rand%0d", cyc), m_cr, ev, ep, er, m_st);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
